// File: rtl/sram_bist_pkg.sv
// rtl/sram_bist_pkg.sv - shared types and helpers for the sram march-test initiator
// Provides the FSM state enum, the byte-write-enable encodings and the
// expected-data function used by both the sequencer and the comparator.
package sram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        P1_WR,
        P2_RD,
        P2_WR,
        P3_RD,
        P3_DRAIN,
        DONE
    } state_t;

    localparam logic [3:0] WEN_WR = 4'hF;
    localparam logic [3:0] WEN_RD = 4'h0;

    // Data seeded by the word index so aliased or swapped words are detected.
    function automatic logic [31:0] expected_word(input logic [31:0] pattern_q,
                                                  input logic [31:0] word_idx);
        return pattern_q ^ word_idx;
    endfunction

endpackage

// File: rtl/sram_bist_cmp.sv
// rtl/sram_bist_cmp.sv - read-data checker with saturating error count and first-error capture
// Ports: clk, resetn (async, active-low), clear (sync), valid strobe,
// expected/rdata/addr of the word being checked; err_count, err_addr, err_data results.
module sram_bist_cmp (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic        valid,
    input  logic [31:0] expected,
    input  logic [31:0] rdata,
    input  logic [31:0] addr,
    output logic [15:0] err_count,
    output logic [31:0] err_addr,
    output logic [31:0] err_data
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_count <= '0;
            err_addr  <= '0;
            err_data  <= '0;
        end else if (clear) begin
            err_count <= '0;
            err_addr  <= '0;
            err_data  <= '0;
        end else if (valid && (rdata != expected)) begin
            if (err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
            // A zero count means no mismatch seen yet: this is the first one.
            if (err_count == 16'd0) begin
                err_addr <= addr;
                err_data <= rdata;
            end
        end
    end

endmodule

// File: rtl/sram_bist_master.sv
// rtl/sram_bist_master.sv - three-pass march-test initiator on the sram-like data port
// Ports: clk, resetn (async, active-low), start/pattern request;
// data_sram_en/wen/addr/wdata/rdata memory port; busy, done, pass,
// err_count, err_addr, err_data status.
module sram_bist_master
    import sram_bist_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          WORDS     = 65536
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] pattern,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [31:0] err_addr,
    output logic [31:0] err_data
);

    localparam int            AW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

    state_t        state;
    logic [AW-1:0] idx;
    logic [31:0]   pattern_q;
    logic          start_ok;

    logic [31:0]   idx32;
    logic [AW-1:0] cmp_idx;
    logic [31:0]   cmp_idx32;
    logic          cmp_valid;
    logic [31:0]   cmp_exp;
    logic [31:0]   cmp_addr;

    assign start_ok = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            idx       <= '0;
            pattern_q <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        pattern_q <= pattern;
                        idx       <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        state     <= P1_WR;
                    end
                end
                P1_WR: begin
                    if (idx == LAST) begin
                        idx   <= '0;
                        state <= P2_RD;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                P2_RD: state <= P2_WR;
                P2_WR: begin
                    // idx stays at LAST: pass 3 starts from the top word.
                    if (idx == LAST) begin
                        state <= P3_RD;
                    end else begin
                        idx   <= idx + AW'(1);
                        state <= P2_RD;
                    end
                end
                P3_RD: begin
                    if (idx == '0) begin
                        state <= P3_DRAIN;
                    end else begin
                        idx <= idx - AW'(1);
                    end
                end
                P3_DRAIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign idx32 = 32'(idx);

    // Memory port is a pure decode of registered state so no input reaches it.
    always_comb begin
        data_sram_en    = 1'b0;
        data_sram_wen   = WEN_RD;
        data_sram_addr  = '0;
        data_sram_wdata = '0;
        case (state)
            P1_WR: begin
                data_sram_en    = 1'b1;
                data_sram_wen   = WEN_WR;
                data_sram_addr  = BASE_ADDR + (idx32 << 2);
                data_sram_wdata = expected_word(pattern_q, idx32);
            end
            P2_RD, P3_RD: begin
                data_sram_en   = 1'b1;
                data_sram_addr = BASE_ADDR + (idx32 << 2);
            end
            P2_WR: begin
                data_sram_en    = 1'b1;
                data_sram_wen   = WEN_WR;
                data_sram_addr  = BASE_ADDR + (idx32 << 2);
                data_sram_wdata = ~expected_word(pattern_q, idx32);
            end
            default: ;
        endcase
    end

    // rdata belongs to the previous read: in P3 that was word idx+1, and the
    // first P3 cycle (idx==LAST) has no read outstanding. In P3_DRAIN idx is 0.
    assign cmp_idx   = (state == P3_RD) ? (idx + AW'(1)) : idx;
    assign cmp_idx32 = 32'(cmp_idx);
    assign cmp_valid = (state == P2_WR) || (state == P3_DRAIN) ||
                       ((state == P3_RD) && (idx != LAST));
    assign cmp_exp   = (state == P2_WR) ? expected_word(pattern_q, cmp_idx32)
                                        : ~expected_word(pattern_q, cmp_idx32);
    assign cmp_addr  = BASE_ADDR + (cmp_idx32 << 2);

    sram_bist_cmp u_cmp (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (start_ok),
        .valid     (cmp_valid),
        .expected  (cmp_exp),
        .rdata     (data_sram_rdata),
        .addr      (cmp_addr),
        .err_count (err_count),
        .err_addr  (err_addr),
        .err_data  (err_data)
    );

    assign pass = done && (err_count == 16'd0);

endmodule

// File: tb/tb_sram_bist_master.sv
// tb/tb_sram_bist_master.sv - directed self-checking bench for sram_bist_master
module tb_sram_bist_master;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [31:0] pattern;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata = 32'h0;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [31:0] err_addr;
    logic [31:0] err_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic        stuck_mode = 1'b0;
    logic        alias_mode = 1'b0;
    logic [31:0] mem [4];
    logic [1:0]  ridx;

    sram_bist_master #(.BASE_ADDR(32'h0000_0000), .WORDS(4)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .start           (start),
        .pattern         (pattern),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .err_addr        (err_addr),
        .err_data        (err_data)
    );

    always #5 clk = ~clk;

    // One-cycle-latency RAM; fault modes: bit 0 of word 1 stuck at 0, or addr[2] ignored.
    assign ridx = alias_mode ? {data_sram_addr[3], 1'b0} : data_sram_addr[3:2];

    always @(posedge clk) begin
        if (data_sram_en) begin
            if (data_sram_wen == 4'hF) begin
                mem[ridx] <= (stuck_mode && ridx == 2'd1) ? (data_sram_wdata & ~32'h1)
                                                          : data_sram_wdata;
            end else begin
                data_sram_rdata <= mem[ridx];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Pulse start so it is sampled at the end of cycle 0; returns in cycle 1.
    task automatic go();
        start = 1'b1;
        cyc   = 0;
        tick();
        start = 1'b0;
    endtask

    initial begin
        resetn  = 1'b0;
        start   = 1'b0;
        pattern = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_en",    32'(data_sram_en), 32'h0);
        chk("rst_wen",   32'(data_sram_wen), 32'h0);
        chk("rst_addr",  data_sram_addr, 32'h0);
        chk("rst_wdata", data_sram_wdata, 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_done",  32'(done), 32'h0);
        chk("rst_pass",  32'(pass), 32'h0);
        chk("rst_errc",  32'(err_count), 32'h0);
        chk("rst_erra",  err_addr, 32'h0);
        chk("rst_errd",  err_data, 32'h0);
        resetn = 1'b1;
        tick();

        // Fault-free run, with ignored start pulses in cycles 5 and 10.
        pattern = 32'hA5A5_0000;
        go();
        for (int k = 0; k < 4; k++) begin
            chk("p1_en",    32'(data_sram_en), 32'h1);
            chk("p1_wen",   32'(data_sram_wen), 32'hF);
            chk("p1_addr",  data_sram_addr, 32'(4 * k));
            chk("p1_wdata", data_sram_wdata, 32'hA5A5_0000 + 32'(k));
            tick();
        end
        chk("c5_busy", 32'(busy), 32'h1);
        chk("c5_wen",  32'(data_sram_wen), 32'h0);
        chk("c5_addr", data_sram_addr, 32'h0);
        start   = 1'b1;
        pattern = 32'hFFFF_FFFF;
        tick();
        start   = 1'b0;
        chk("c6_wen",   32'(data_sram_wen), 32'hF);
        chk("c6_wdata", data_sram_wdata, 32'h5A5A_FFFF);
        while (cyc < 10) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < 13) tick();
        chk("c13_addr", data_sram_addr, 32'hC);
        chk("c13_wen",  32'(data_sram_wen), 32'h0);
        tick();
        chk("c14_addr", data_sram_addr, 32'h8);
        while (cyc < 17) tick();
        chk("c17_en",   32'(data_sram_en), 32'h0);
        chk("c17_busy", 32'(busy), 32'h1);
        chk("c17_done", 32'(done), 32'h0);
        tick();
        chk("ok_done", 32'(done), 32'h1);
        chk("ok_busy", 32'(busy), 32'h0);
        chk("ok_pass", 32'(pass), 32'h1);
        chk("ok_errc", 32'(err_count), 32'h0);

        // Stuck-at-0 on bit 0 of word 1.
        pattern    = 32'hA5A5_0000;
        stuck_mode = 1'b1;
        go();
        while (cyc < 18) tick();
        chk("sa_done", 32'(done), 32'h1);
        chk("sa_pass", 32'(pass), 32'h0);
        chk("sa_errc", 32'(err_count), 32'h1);
        chk("sa_erra", err_addr, 32'h4);
        chk("sa_errd", err_data, 32'hA5A5_0000);

        // Restart from DONE clears results; fault-free rerun passes.
        stuck_mode = 1'b0;
        go();
        chk("rs_done", 32'(done), 32'h0);
        chk("rs_busy", 32'(busy), 32'h1);
        chk("rs_errc", 32'(err_count), 32'h0);
        chk("rs_erra", err_addr, 32'h0);
        while (cyc < 18) tick();
        chk("rs_fdone", 32'(done), 32'h1);
        chk("rs_pass",  32'(pass), 32'h1);

        // Address alias: addr[2] ignored, words 0/1 and 2/3 collapse.
        alias_mode = 1'b1;
        go();
        while (cyc < 18) tick();
        chk("al_done", 32'(done), 32'h1);
        chk("al_pass", 32'(pass), 32'h0);
        chk("al_errc", 32'(err_count), 32'h6);
        chk("al_erra", err_addr, 32'h0);
        chk("al_errd", err_data, 32'hA5A5_0001);

        // Reset during cycle 7 aborts the test.
        alias_mode = 1'b0;
        go();
        while (cyc < 7) tick();
        chk("ab_busy0", 32'(busy), 32'h1);
        resetn = 1'b0;
        #1;
        chk("ab_en",   32'(data_sram_en), 32'h0);
        chk("ab_busy", 32'(busy), 32'h0);
        chk("ab_done", 32'(done), 32'h0);
        #3;
        resetn = 1'b1;
        tick();
        chk("ab_idle_busy", 32'(busy), 32'h0);
        chk("ab_idle_en",   32'(data_sram_en), 32'h0);
        go();
        while (cyc < 17) tick();
        chk("ab_c17_done", 32'(done), 32'h0);
        tick();
        chk("ab_fdone", 32'(done), 32'h1);
        chk("ab_pass",  32'(pass), 32'h1);
        chk("ab_errc",  32'(err_count), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_bist_master.md
# sram_bist_master

Built-in self-test initiator for the SoC's sram-like data port (en/wen/addr/wdata/rdata, fixed one-cycle read latency). It takes the place of the CPU on the initiator side of the interface and drives a data RAM or bridge directly. On a start pulse it runs a three-pass march test over a parameterised word range. It reports pass/fail, an error count, and the first failing address and data.

## Interface
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word-aligned.
- WORDS, 65536, number of 32-bit words tested; power of two, 2..65536.
- clk  in  1  clock; all logic on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE or DONE.
- pattern  in  32  seed data; sampled on the cycle start is accepted.
- data_sram_en  out  1  access enable.
- data_sram_wen  out  4  byte write enables; 4'hF for writes, 4'h0 for reads.
- data_sram_addr  out  32  byte address, BASE_ADDR + {i, 2'b00}.
- data_sram_wdata  out  32  write data.
- data_sram_rdata  in  32  read data; valid the cycle after a read.
- busy  out  1  test in progress.
- done  out  1  level; set at test end, held until the next accepted start.
- pass  out  1  valid while done=1; 1 when err_count is 0.
- err_count  out  16  number of mismatches; saturates at 16'hFFFF.
- err_addr  out  32  byte address of the first mismatch.
- err_data  out  32  read data of the first mismatch.

## Operation
- Expected value for word i: E(i) = pattern_q ^ zero-extended i.
- pattern_q is the registered copy of pattern.
- States: IDLE, P1_WR, P2_RD, P2_WR, P3_RD, P3_DRAIN, DONE.
- IDLE/DONE to P1_WR on start:
  - latch pattern;
  - clear err_count, err_addr, err_data, done;
  - set busy;
  - set i=0.
- P1_WR, ascending:
  - write E(i) to word i each cycle;
  - at i=WORDS-1, set i=0 and go to P2_RD.
- P2_RD:
  - read word i;
  - go to P2_WR.
- P2_WR:
  - compare rdata with E(i);
  - write ~E(i) to word i;
  - if i=WORDS-1, set i=WORDS-1 and go to P3_RD; else i++ and go to P2_RD.
- P3_RD, descending:
  - read word i each cycle;
  - compare the previous cycle's rdata with ~E(i+1), except on the first P3 cycle;
  - at i=0, go to P3_DRAIN.
- P3_DRAIN:
  - compare rdata with ~E(0);
  - en=0;
  - go to DONE.
- DONE:
  - busy=0, done=1;
  - pass = (err_count==0) including the drain compare.
- Mismatch handling: err_count increments with saturation. On the first mismatch only, err_addr and err_data are captured.
- data_sram_en is high in every P1–P3 state and low in IDLE, P3_DRAIN and DONE.
- start is ignored while busy.
- start in DONE restarts the test identically to start in IDLE.
- i is log2(WORDS) bits wide.
  - The address adder is 32 bits, with wrap-around modulo 2^32.
  - The XOR with i is zero-extended to 32 bits.

## Timing
- Reset (async, immediate): state=IDLE.
  - en=0, wen=0, addr=0, wdata=0.
  - busy=0, done=0, pass=0.
  - err_count=0, err_addr=0, err_data=0.
- Interface outputs are decoded from registered state/counter only. No input-to-output combinational path.
- start high in cycle 0 gives:
  - first access in cycle 1;
  - P1 in cycles 1..N;
  - P2 in cycles N+1..3N, at 2 cycles per word;
  - P3 reads in cycles 3N+1..4N;
  - drain in cycle 4N+1;
  - done=1 and busy=0 from cycle 4N+2.
- busy is high in cycles 1..4N+1.
- Read data is consumed exactly one cycle after its read; rdata is never sampled in any other cycle.
- When resetn is deasserted mid-test, the test aborts. No partial results are retained, and a fresh start is required.

## Structure
- Shared package sram_bist_pkg:
  - state enum;
  - WEN_WR = 4'hF and WEN_RD = 4'h0;
  - function for the expected value.
- One sub-module, sram_bist_cmp:
  - inputs: compare-valid strobe, expected value, rdata, address;
  - maintains the saturating err_count and the first-error capture registers;
  - has a synchronous clear driven on start.
- The FSM and the address counter stay in the top module.

## Test plan
All scenarios use WORDS=4, BASE_ADDR=0, pattern=32'hA5A5_0000, with a one-cycle-latency behavioural RAM model.

- Fault-free run, start in cycle 0:
  - writes 0/4/8/C with A5A50000..A5A50003 in cycles 1–4;
  - done=1 and pass=1 at cycle 18;
  - err_count=0.
- Stuck-at-0 on bit 0 of word at 0x4:
  - err_count=1, pass=0;
  - err_addr=32'h4, err_data=32'hA5A5_0000.
- Address alias, with the model ignoring addr[2]:
  - pass=0, err_count≥1;
  - err_addr=32'h0, err_data=32'hA5A5_0001.
- start pulses at cycles 5 and 10 while busy: no effect, done still at cycle 18.
- resetn low during cycle 7, in P2:
  - en, busy and done go to 0 immediately;
  - a new start after release completes in 4N+2 cycles with pass=1.
- Restart from DONE after the failing run:
  - done, err_count and err_addr clear the cycle after start;
  - a fault-free rerun ends with pass=1.
